// File: rtl/lod_pkg.sv
// Shared types and widths for the leading-one normalizer.
package lod_pkg;

    localparam int LOD_W  = 8;
    localparam int POS_W  = 3;
    localparam int LD_O_W = 4;

    typedef struct packed {
        logic [LOD_W-1:0] norm;
        logic [POS_W-1:0] shift;
        logic [POS_W-1:0] exp;
        logic             zero;
    } lod_res_t;

endpackage

// File: rtl/leading_one.sv
// 8-bit leading-one detector: ld_o[3] flags a nonzero word, ld_o[2:0] is the
// index of the most significant set bit (0 when the word is zero).
module leading_one
    import lod_pkg::*;
(
    input  logic [LOD_W-1:0]  check_bits,
    output logic [LD_O_W-1:0] ld_o
);

    logic [POS_W-1:0] pos;

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        pos = '0;
        for (int i = 0; i < LOD_W; i++) begin
            if (check_bits[i]) begin
                pos = POS_W'(i);
            end
        end
    end

    assign ld_o = {|check_bits, pos};

endmodule

// File: rtl/lod_normalizer.sv
// Two-stage normalizer: S1 captures the word and its leading-one position,
// S2 shifts the leading one up to the MSB and holds the result for the consumer.
module lod_normalizer #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_norm,
    output logic [2:0]       out_shift,
    output logic [2:0]       out_exp,
    output logic             out_zero,
    input  logic             zcnt_clr,
    output logic [CNT_W-1:0] zcnt
);

    import lod_pkg::*;

    logic [LD_O_W-1:0] ld_o;

    logic              s1_v_q, s1_v_d;
    logic [LOD_W-1:0]  data_q, data_d;
    logic [POS_W-1:0]  pos_q,  pos_d;
    logic              zero_q, zero_d;

    logic              s2_v_q, s2_v_d;
    lod_res_t          res_q,  res_d;
    lod_res_t          res_c;
    logic [POS_W-1:0]  shift_c;

    logic [CNT_W-1:0]  zcnt_q, zcnt_d;

    logic              s1_adv, s2_adv;

    leading_one u_leading_one (
        .check_bits (in_data),
        .ld_o       (ld_o)
    );

    // Pipeline advance: a stage moves when it is empty or its successor moves.
    always_comb begin
        s2_adv = !s2_v_q || out_ready;
        s1_adv = !s1_v_q || s2_adv;
    end

    assign in_ready = s1_adv;

    // S1 next state: capture the word and detector result on an accepted handshake.
    always_comb begin
        s1_v_d = s1_v_q;
        data_d = data_q;
        pos_d  = pos_q;
        zero_d = zero_q;
        if (s1_adv) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
                pos_d  = ld_o[POS_W-1:0];
                zero_d = !ld_o[LD_O_W-1];
            end
        end
    end

    // Normalize S1's word; a zero word forces every field to 0 except the flag.
    always_comb begin
        shift_c    = {POS_W{1'b1}} - pos_q;
        res_c      = '0;
        res_c.zero = zero_q;
        if (!zero_q) begin
            res_c.norm  = data_q << shift_c;
            res_c.shift = shift_c;
            res_c.exp   = pos_q;
        end
    end

    // S2 next state: results only change when a valid word moves in, so the
    // outputs keep the last delivered value while the pipe drains.
    always_comb begin
        s2_v_d = s2_v_q;
        res_d  = res_q;
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                res_d = res_c;
            end
        end
    end

    // Saturating zero-word counter; clear overrides a same-cycle increment.
    always_comb begin
        zcnt_d = zcnt_q;
        if (zcnt_clr) begin
            zcnt_d = '0;
        end else if (s2_v_q && out_ready && res_q.zero && (zcnt_q != {CNT_W{1'b1}})) begin
            zcnt_d = zcnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            data_q <= '0;
            pos_q  <= '0;
            zero_q <= 1'b0;
            s2_v_q <= 1'b0;
            res_q  <= '0;
            zcnt_q <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            data_q <= data_d;
            pos_q  <= pos_d;
            zero_q <= zero_d;
            s2_v_q <= s2_v_d;
            res_q  <= res_d;
            zcnt_q <= zcnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_norm  = res_q.norm;
    assign out_shift = res_q.shift;
    assign out_exp   = res_q.exp;
    assign out_zero  = res_q.zero;
    assign zcnt      = zcnt_q;

endmodule

// File: tb/tb_lod_normalizer.sv
// Directed bench for lod_normalizer: basic words, zero counting, backpressure,
// counter saturation (second instance with a 2-bit counter) and mid-stream reset.
module tb_lod_normalizer;

    import lod_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_norm;
    logic [2:0]  out_shift;
    logic [2:0]  out_exp;
    logic        out_zero;
    logic        zcnt_clr;
    logic [15:0] zcnt;

    logic        in_ready2, out_valid2, out_zero2;
    logic [7:0]  out_norm2;
    logic [2:0]  out_shift2, out_exp2;
    logic [1:0]  zcnt2;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    lod_normalizer #(.W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_norm(out_norm), .out_shift(out_shift), .out_exp(out_exp), .out_zero(out_zero),
        .zcnt_clr(zcnt_clr), .zcnt(zcnt)
    );

    lod_normalizer #(.W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_norm(out_norm2), .out_shift(out_shift2), .out_exp(out_exp2), .out_zero(out_zero2),
        .zcnt_clr(zcnt_clr), .zcnt(zcnt2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic lod_res_t mk(input logic [7:0] n, input logic [2:0] s,
                                    input logic [2:0] e, input logic z);
        lod_res_t r;
        r.norm = n; r.shift = s; r.exp = e; r.zero = z;
        return r;
    endfunction

    function automatic lod_res_t obs_res();
        return mk(out_norm, out_shift, out_exp, out_zero);
    endfunction

    logic [7:0] bp_words [8];
    lod_res_t   bp_exp   [8];

    initial begin
        int ni, gi, budget;
        logic acc;

        bp_words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        bp_exp[0] = mk(8'h80, 3'd7, 3'd0, 1'b0);
        bp_exp[1] = mk(8'h80, 3'd6, 3'd1, 1'b0);
        bp_exp[2] = mk(8'hC0, 3'd6, 3'd1, 1'b0);
        bp_exp[3] = mk(8'h80, 3'd5, 3'd2, 1'b0);
        bp_exp[4] = mk(8'hA0, 3'd5, 3'd2, 1'b0);
        bp_exp[5] = mk(8'hC0, 3'd5, 3'd2, 1'b0);
        bp_exp[6] = mk(8'hE0, 3'd5, 3'd2, 1'b0);
        bp_exp[7] = mk(8'h80, 3'd4, 3'd3, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1; zcnt_clr = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_outputs",   32'(obs_res()), 32'(mk(8'h00, 3'd0, 3'd0, 1'b0)));
        chk("rst_zcnt",      32'(zcnt),      32'd0);

        // Basic word, two-cycle latency
        in_valid = 1'b1; in_data = 8'b0000_1110;
        tick();
        in_valid = 1'b0; in_data = 8'hFF;
        chk("basic_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_res",   32'(obs_res()), 32'(mk(8'b1110_0000, 3'd4, 3'd3, 1'b0)));
        tick();
        chk("basic_drained", 32'(out_valid), 32'd0);

        // Two more words back-to-back
        in_valid = 1'b1; in_data = 8'b0010_1101;
        tick();
        in_data = 8'h80;
        tick();
        in_valid = 1'b0;
        chk("word2d_res", 32'(obs_res()), 32'(mk(8'b1011_0100, 3'd2, 3'd5, 1'b0)));
        tick();
        chk("word80_valid", 32'(out_valid), 32'd1);
        chk("word80_res",   32'(obs_res()), 32'(mk(8'h80, 3'd0, 3'd7, 1'b0)));
        tick();

        // Zero words and counter
        in_valid = 1'b1; in_data = 8'h00;
        tick();
        in_data = 8'h01;
        tick();
        chk("zero_a_res", 32'(obs_res()), 32'(mk(8'h00, 3'd0, 3'd0, 1'b1)));
        in_data = 8'h00;
        tick();
        chk("zero_b_res", 32'(obs_res()), 32'(mk(8'h80, 3'd7, 3'd0, 1'b0)));
        chk("zero_b_zcnt", 32'(zcnt), 32'd1);
        in_valid = 1'b0;
        tick();
        chk("zero_c_valid", 32'(out_valid), 32'd1);
        chk("zero_c_res",   32'(obs_res()), 32'(mk(8'h00, 3'd0, 3'd0, 1'b1)));
        tick();
        chk("zcnt_two", 32'(zcnt), 32'd2);

        // Clear coinciding with a zero handshake
        in_valid = 1'b1; in_data = 8'h00;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_zero_present", 32'({out_valid, out_zero}), 32'b11);
        zcnt_clr = 1'b1;
        tick();
        zcnt_clr = 1'b0;
        chk("clr_wins", 32'(zcnt), 32'd0);

        // Backpressure: stall 5 cycles after first out_valid
        in_valid = 1'b1; in_data = bp_words[0];
        tick();
        in_data = bp_words[1];
        tick();
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b0;
        in_data = bp_words[2];
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            in_data = 8'h5A ^ 8'(k);
            #1;
            chk("bp_stall_in_ready", 32'(in_ready),  32'd0);
            chk("bp_stall_norm",     32'(out_norm),  32'h80);
            chk("bp_stall_valid",    32'(out_valid), 32'd1);
        end
        in_data = bp_words[2];
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        ni = 2; gi = 0; budget = 0;
        while (gi < 8 && budget < 30) begin
            if (out_valid) begin
                chk("bp_stream_res", 32'(obs_res()), 32'(bp_exp[gi]));
                gi++;
            end
            acc = in_valid && in_ready;
            tick();
            budget++;
            if (acc) begin
                ni++;
                in_valid = (ni < 8);
                in_data  = (ni < 8) ? bp_words[ni] : 8'hFF;
            end
        end
        chk("bp_all_received", 32'(gi), 32'd8);
        in_valid = 1'b0;
        tick();
        chk("bp_no_extra", 32'(out_valid), 32'd0);

        // Saturation on the 2-bit counter instance
        zcnt_clr = 1'b1;
        tick();
        zcnt_clr = 1'b0;
        chk("sat_cleared", 32'(zcnt2), 32'd0);
        in_valid = 1'b1; in_data = 8'h00;
        for (int k = 0; k < 5; k++) tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("sat_wide_count", 32'(zcnt),  32'd5);
        chk("sat_stops_at_3", 32'(zcnt2), 32'd3);

        // Reset with both stages full
        in_valid = 1'b1; in_data = 8'h01;
        tick();
        in_data = 8'h02;
        tick();
        out_ready = 1'b0;
        in_data = 8'h03;
        #1;
        chk("rstm_full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rstm_out_valid", 32'(out_valid), 32'd0);
        chk("rstm_zcnt",      32'(zcnt),      32'd0);
        chk("rstm_in_ready",  32'(in_ready),  32'd1);
        chk("rstm_outputs",   32'(obs_res()), 32'(mk(8'h00, 3'd0, 3'd0, 1'b0)));
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'b0000_1110;
        tick();
        in_valid = 1'b0;
        chk("rstm_lat1", 32'(out_valid), 32'd0);
        tick();
        chk("rstm_first_valid", 32'(out_valid), 32'd1);
        chk("rstm_first_res",   32'(obs_res()), 32'(mk(8'b1110_0000, 3'd4, 3'd3, 1'b0)));
        tick();
        chk("rstm_no_dup", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
